// File: rtl/mul_div_pkg.sv
// Shared encodings and width defaults for the iterative multiply/divide unit.
// Widths must stay in step with reg_file.
package mul_div_pkg;

    localparam int MD_DATA_WIDTH = 32;
    localparam int MD_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation. The carry-in lets the upper word of a
// double-width value be negated using the borrow from the lower word.
module sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    input  logic             cin,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + WIDTH'(cin)) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 iterative 32-bit multiply/divide unit feeding the reg_file write-back path.
// Magnitudes are processed unsigned; signs are applied once at completion.
module mul_div_unit #(
    parameter int DATA_WIDTH = mul_div_pkg::MD_DATA_WIDTH,
    parameter int ADDR_WIDTH = mul_div_pkg::MD_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic [DATA_WIDTH-1:0] out_lo,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic [1:0]            state_dbg
);
    import mul_div_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid, once raised, holds its payload stable until that edge.
    state_e                state_q, state_d;
    logic                  is_div_q, neg_lo_q, neg_hi_q;
    logic [DATA_WIDTH-1:0] acc_q, q_q, b_q;
    logic [CW-1:0]         cnt_q;

    logic                  is_signed, is_div, sa, sb, div_by_zero, accept, last;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH:0]   mul_sum, rem_sh, diff;
    logic [DATA_WIDTH-1:0] acc_n, q_n, fix_hi, fix_lo;
    logic                  ge, hi_cin;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign state_dbg = state_q;

    assign is_signed   = (op == OP_MUL) || (op == OP_DIV);
    assign is_div      = (op == OP_DIVU) || (op == OP_DIV);
    assign sa          = is_signed & src_a[DATA_WIDTH-1];
    assign sb          = is_signed & src_b[DATA_WIDTH-1];
    assign div_by_zero = is_div && (src_b == '0);
    assign accept      = in_ready && in_valid;
    assign last        = (cnt_q == CW'(DATA_WIDTH-1));

    sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_a (.val(src_a), .neg(sa), .cin(1'b1), .res(abs_a));
    sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_b (.val(src_b), .neg(sb), .cin(1'b1), .res(abs_b));

    // Multiply: {acc, q} shifts right, adding b when the multiplier LSB is set.
    // Divide: {acc, q} shifts left, restoring subtract of b into acc.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = {acc_q, q_q[DATA_WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        ge      = ~diff[DATA_WIDTH];
        if (is_div_q) begin
            acc_n = ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
            q_n   = {q_q[DATA_WIDTH-2:0], ge};
        end else begin
            acc_n = mul_sum[DATA_WIDTH:1];
            q_n   = {mul_sum[0], q_q[DATA_WIDTH-1:1]};
        end
    end

    // A double-width negation carries into hi only when lo is zero.
    assign hi_cin = is_div_q ? 1'b1 : (q_n == '0);

    sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_lo (.val(q_n),   .neg(neg_lo_q), .cin(1'b1),   .res(fix_lo));
    sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_hi (.val(acc_n), .neg(neg_hi_q), .cin(hi_cin), .res(fix_hi));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = div_by_zero ? S_DONE : S_BUSY;
            S_BUSY:  if (last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            out_hi    <= '0;
            out_lo    <= '0;
            out_waddr <= '0;
        end else if (accept) begin
            is_div_q  <= is_div;
            neg_lo_q  <= sa ^ sb;
            neg_hi_q  <= is_div ? sa : (sa ^ sb);
            acc_q     <= '0;
            q_q       <= abs_a;
            b_q       <= abs_b;
            cnt_q     <= '0;
            out_waddr <= dst;
            if (div_by_zero) begin
                out_hi <= src_a;
                out_lo <= '1;
            end
        end else if (state_q == S_BUSY) begin
            acc_q <= acc_n;
            q_q   <= q_n;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                out_hi <= fix_hi;
                out_lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed results and a small
// reg_file model on the write-back path.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, out_hi, out_lo;
    logic [4:0]  dst, out_waddr;
    logic [1:0]  state_dbg;
    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hi(out_hi), .out_lo(out_lo), .out_waddr(out_waddr),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // reg_file write port driven from the unit's result
    always @(posedge clk) begin
        if (out_valid && out_ready) rf[out_waddr] <= out_lo;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        @(negedge clk);
        in_valid = 1'b1; op = o; src_a = a; src_b = b; dst = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic expect_out(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                              input logic [4:0] wa);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hi"}, 64'(out_hi), 64'(hi));
        check({tag, "_lo"}, 64'(out_lo), 64'(lo));
        check({tag, "_waddr"}, 64'(out_waddr), 64'(wa));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; dst = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_hi", 64'(out_hi), 64'd0);
        check("rst_lo", 64'(out_lo), 64'd0);
        check("rst_waddr", 64'(out_waddr), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);

        // Reset while busy discards the partial product
        issue(2'b00, 32'd7, 32'd6, 5'd3);
        repeat (9) @(negedge clk);
        check("busy_in_ready", 64'(in_ready), 64'd0);
        check("busy_state", 64'(state_dbg), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_waddr", 64'(out_waddr), 64'd0);
        check("midrst_lo", 64'(out_lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'b00, 32'd7, 32'd6, 5'd3);
        wait_result("mulu_7x6", 32);
        expect_out("mulu_7x6", 32'd0, 32'd42, 5'd3);
        release_out("mulu_7x6");

        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 5'd4);
        wait_result("mul_m3x5", 32);
        expect_out("mul_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5'd4);
        release_out("mul_m3x5");

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 5'd4);
        wait_result("mulu_fffd_x5", 32);
        expect_out("mulu_fffd_x5", 32'h0000_0004, 32'hFFFF_FFF1, 5'd4);
        release_out("mulu_fffd_x5");

        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6);
        wait_result("mul_min_sq", 32);
        expect_out("mul_min_sq", 32'h4000_0000, 32'h0000_0000, 5'd6);
        release_out("mul_min_sq");

        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd7);
        wait_result("div_m7_2", 32);
        expect_out("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5'd7);
        release_out("div_m7_2");

        issue(2'b10, 32'h0000_1234, 32'd0, 5'd8);
        wait_result("divu_by0", 0);
        expect_out("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF, 5'd8);
        release_out("divu_by0");

        issue(2'b11, 32'hFFFF_FFF0, 32'd0, 5'd9);
        wait_result("div_neg_by0", 0);
        expect_out("div_neg_by0", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 5'd9);
        release_out("div_neg_by0");

        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        wait_result("div_min_m1", 32);
        expect_out("div_min_m1", 32'h0000_0000, 32'h8000_0000, 5'd10);
        release_out("div_min_m1");

        // Backpressure: result held while a new request waits
        issue(2'b10, 32'd100, 32'd7, 5'd11);
        wait_result("divu_100_7", 32);
        in_valid = 1'b1; op = 2'b00; src_a = 32'h11; src_b = 32'h10; dst = 5'd12;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hi", 64'(out_hi), 64'd2);
            check("bp_lo", 64'(out_lo), 64'd14);
        end
        expect_out("divu_100_7", 32'd2, 32'd14, 5'd11);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", 64'(in_ready), 64'd0);
        wait_result("bp_next", 32);
        expect_out("bp_next", 32'd0, 32'h110, 5'd12);
        release_out("bp_next");

        // Write-back into the reg_file model
        issue(2'b00, 32'd3, 32'd4, 5'd5);
        wait_result("wb_3x4", 32);
        release_out("wb_3x4");
        check("wb_rdata_r5", 64'(rf[5]), 64'd12);
        check("wb_rdata_r12", 64'(rf[12]), 64'h110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit that sits directly downstream of reg_file.
- Consumes the two read operands (rdata1/rdata2) and the destination register number from the issue logic.
- Returns a {hi, lo} result plus write address so the write-back path can drive reg_file waddr/wdata/wen.
- Radix-2, one bit per cycle; valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- ADDR_WIDTH, 5, register-address width; must match reg_file.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- op  input  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- src_a  input  DATA_WIDTH  multiplicand / dividend (from rdata1)
- src_b  input  DATA_WIDTH  multiplier / divisor (from rdata2)
- dst  input  ADDR_WIDTH  destination register
- out_valid  output  1  result present
- out_ready  input  1  write-back accepts result
- out_hi  output  DATA_WIDTH  MUL: product[63:32]; DIV: remainder
- out_lo  output  DATA_WIDTH  MUL: product[31:0]; DIV: quotient
- out_waddr  output  ADDR_WIDTH  latched dst

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - out_hi, out_lo, out_waddr, iteration counter = 0.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. When in_valid is high on a clock edge:
    - latch op, dst, |src_a|, |src_b| (absolute values only for signed ops) and the result signs.
    - clear accumulator, counter = 0.
    - go to BUSY.
    - Exception: for DIV/DIVU with src_b == 0, go directly to DONE.
  - BUSY: in_ready = 0, out_valid = 0.
    - One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; counter increments.
    - On the edge where counter == DATA_WIDTH-1: apply the sign fix, load out_hi/out_lo, go to DONE.
  - DONE: out_valid = 1; out_hi, out_lo, out_waddr held stable.
    - On an edge with out_ready = 1: go to IDLE.
    - in_ready = 0 while in DONE; no accept/complete overlap.
- Latency: request accepted on edge E0 -> out_valid high after edge E0+DATA_WIDTH (32 BUSY cycles). Divide-by-zero: out_valid high after E0.
- Throughput: at most one request per DATA_WIDTH+2 cycles when out_ready is held high.
- Sign rules (signed ops):
  - product sign = sign(a) XOR sign(b).
  - quotient sign = sign(a) XOR sign(b).
  - remainder sign = sign(a).
  - Magnitudes are computed unsigned and negated (two's complement) when the sign bit is set.
- Boundaries:
  - Divide by zero: out_lo = all ones, out_hi = src_a (unmodified, any op).
  - DIV with 0x80000000 / 0xFFFFFFFF: out_lo = 0x80000000, out_hi = 0, via the normal path (no special case required; result must match).
  - MUL with 0x80000000 * 0x80000000: {hi, lo} = 0x40000000_00000000.
  - in_valid held high while not ready: ignored; the operands must not be sampled.
  - out_ready held low: DONE holds indefinitely; outputs stable.
  - rst_n low in any state: immediate return to reset values; a partial result is discarded.
- Write-back: wen = out_valid & out_ready, wdata = out_lo, waddr = out_waddr. The hi register is out of scope.

Decomposition:
- Shared package mul_div_pkg holds:
  - op encodings OP_MULU/OP_MUL/OP_DIVU/OP_DIV.
  - state encoding S_IDLE/S_BUSY/S_DONE.
  - DATA_WIDTH/ADDR_WIDTH defaults shared with reg_file.
- One combinational sub-module, sign_fix: conditional two's-complement negation for a DATA_WIDTH value. Instantiated for the operand abs at accept and for the result fix at completion.

Test Plan:
- Reset mid-BUSY: MULU 7*6, assert rst_n low at cycle 10 -> out_valid = 0, in_ready = 1, outputs 0 immediately. Then MULU 7*6 -> hi = 0, lo = 42 after 32 cycles.
- Signed MUL 0xFFFFFFFD(-3) * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULU same operands -> hi = 0x00000004, lo = 0xFFFFFFF1.
- DIV -7 / 2 -> lo = 0xFFFFFFFD(-3), hi = 0xFFFFFFFF(-1). DIVU 100 / 7 -> lo = 14, hi = 2.
- DIVU 0x1234 / 0 -> out_valid one cycle after accept, lo = 0xFFFFFFFF, hi = 0x1234. DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- Backpressure: out_ready low for 10 cycles in DONE, in_valid high with new operands -> outputs stable, in_ready = 0, new operands not captured. Raise out_ready -> IDLE, next request accepted.
- Write-back integration: dst = 5, MULU 3*4, drive reg_file from out_* -> rdata1 at raddr1 = 5 reads 12.
